// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - shared constants and types for the RV32M execute unit
package ex_muldiv_unit_pkg;

  localparam logic [2:0] FU_ALU = 3'd0;
  localparam logic [2:0] FU_BRU = 3'd1;
  localparam logic [2:0] FU_LSU = 3'd2;
  localparam logic [2:0] FU_MDU = 3'd3;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - register-read bundle, result, and recovery signals of the mul/div unit
interface ex_muldiv_unit_if #(parameter int ROB_W = 3);
  logic                   RR_valid;
  logic [2:0]             RR_out_fu_sel;
  logic [2:0]             RR_out_f3;
  logic [31:0]            RR_out_rs1_data;
  logic [31:0]            RR_out_rs2_data;
  logic [6:0]             RR_out_rd;
  logic [ROB_W-1:0]       RR_out_rob_idx;
  logic                   mdu_ready;
  logic                   EX_out_valid;
  logic [31:0]            EX_out_data;
  logic [6:0]             EX_out_rd;
  logic [ROB_W-1:0]       EX_out_rob_idx;
  logic                   EX_out_ready;
  logic                   mispredict;
  logic [(1<<ROB_W)-1:0]  flush_mask;

  modport master (
    output RR_valid, RR_out_fu_sel, RR_out_f3, RR_out_rs1_data, RR_out_rs2_data,
           RR_out_rd, RR_out_rob_idx, EX_out_ready, mispredict, flush_mask,
    input  mdu_ready, EX_out_valid, EX_out_data, EX_out_rd, EX_out_rob_idx
  );

  modport slave (
    input  RR_valid, RR_out_fu_sel, RR_out_f3, RR_out_rs1_data, RR_out_rs2_data,
           RR_out_rd, RR_out_rob_idx, EX_out_ready, mispredict, flush_mask,
    output mdu_ready, EX_out_valid, EX_out_data, EX_out_rd, EX_out_rob_idx
  );
endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// rtl/ex_muldiv_unit_div_core.sv - radix-2 restoring unsigned divider, one quotient bit per cycle
module mdu_div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic        r_busy;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_div;
  logic [32:0] w_shift;
  logic [31:0] w_sub;
  logic        w_fits;

  // r_quot holds the not-yet-consumed dividend bits and collects quotient bits from the bottom
  assign w_shift     = {r_rem, r_quot[31]};
  assign w_fits      = w_shift >= {1'b0, r_div};
  assign w_sub       = w_shift[31:0] - r_div;
  assign o_remainder = w_fits ? w_sub : w_shift[31:0];
  assign o_quotient  = {r_quot[30:0], w_fits};
  // o_quotient/o_remainder are final on the cycle o_done is high
  assign o_done      = r_busy && (r_cnt == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= 5'd0;
      r_rem  <= 32'd0;
      r_quot <= 32'd0;
      r_div  <= 32'd0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= 5'd31;
      r_rem  <= 32'd0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      r_rem  <= o_remainder;
      r_quot <= o_quotient;
      r_cnt  <= r_cnt - 5'd1;
      if (r_cnt == 5'd0) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M execute unit: fixed-latency multiply, iterative divide, held result
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter logic [2:0] FU_ID   = FU_MDU,
  parameter int         MUL_LAT = 2,
  parameter int         ROB_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_unit_if.slave  bus
);

  mdu_state_t       r_state, w_next;
  logic [31:0]      r_data, r_mul_res;
  logic [6:0]       r_rd;
  logic [ROB_W-1:0] r_rob;
  logic [1:0]       r_mul_cnt;
  logic             r_neg_q, r_neg_r, r_is_rem;

  logic [31:0] w_a, w_b, w_abs_a, w_abs_b, w_mul_res, w_special_res;
  logic [31:0] w_div_q, w_div_r, w_div_res;
  logic [32:0] w_mul_a, w_mul_b;
  logic [63:0] w_prod;
  logic        w_accept, w_flush, w_is_div, w_div_signed, w_a_neg, w_b_neg;
  logic        w_div_zero, w_div_ovf, w_special, w_div_done, w_is_rem;

  assign w_a      = bus.RR_out_rs1_data;
  assign w_b      = bus.RR_out_rs2_data;
  assign w_accept = bus.RR_valid && (bus.RR_out_fu_sel == FU_ID) && (r_state == IDLE) &&
                    !(bus.mispredict && bus.flush_mask[bus.RR_out_rob_idx]);
  assign w_flush  = bus.mispredict && bus.flush_mask[r_rob];

  // 33-bit operands make every signedness combination a plain signed multiply
  assign w_mul_a   = {(bus.RR_out_f3 == F3_MULH || bus.RR_out_f3 == F3_MULHSU) && w_a[31], w_a};
  assign w_mul_b   = {(bus.RR_out_f3 == F3_MULH) && w_b[31], w_b};
  assign w_prod    = {{31{w_mul_a[32]}}, w_mul_a} * {{31{w_mul_b[32]}}, w_mul_b};
  assign w_mul_res = (bus.RR_out_f3 == F3_MUL) ? w_prod[31:0] : w_prod[63:32];

  assign w_is_div      = bus.RR_out_f3[2];
  assign w_is_rem      = bus.RR_out_f3[1];
  assign w_div_signed  = (bus.RR_out_f3 == F3_DIV) || (bus.RR_out_f3 == F3_REM);
  assign w_a_neg       = w_div_signed && w_a[31];
  assign w_b_neg       = w_div_signed && w_b[31];
  assign w_abs_a       = w_a_neg ? (32'd0 - w_a) : w_a;
  assign w_abs_b       = w_b_neg ? (32'd0 - w_b) : w_b;
  assign w_div_zero    = (w_b == 32'd0);
  assign w_div_ovf     = w_div_signed && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
  assign w_special     = w_div_zero || w_div_ovf;
  assign w_special_res = w_is_rem ? (w_div_zero ? w_a : 32'd0)
                                  : (w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

  mdu_div_core u_div (
    .clk         (clk),
    .rst_n       (rst),
    .i_start     (w_accept && w_is_div && !w_special),
    .i_abort     (w_flush && (r_state == DIV)),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  assign w_div_res = r_is_rem ? (r_neg_r ? (32'd0 - w_div_r) : w_div_r)
                              : (r_neg_q ? (32'd0 - w_div_q) : w_div_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Flush wins over completion and over the writeback grant
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (!w_is_div)     w_next = (MUL_LAT == 1) ? DONE : MUL;
        else if (w_special) w_next = DONE;
        else               w_next = DIV;
      end
      MUL:  if (w_flush) w_next = IDLE; else if (r_mul_cnt == 2'd1) w_next = DONE;
      DIV:  if (w_flush) w_next = IDLE; else if (w_div_done) w_next = DONE;
      DONE: if (w_flush || bus.EX_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mdu_ready      = (r_state == IDLE);
    bus.EX_out_valid   = (r_state == DONE);
    bus.EX_out_data    = r_data;
    bus.EX_out_rd      = r_rd;
    bus.EX_out_rob_idx = r_rob;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= 32'd0;
      r_mul_res <= 32'd0;
      r_rd      <= 7'd0;
      r_rob     <= '0;
      r_mul_cnt <= 2'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd      <= bus.RR_out_rd;
        r_rob     <= bus.RR_out_rob_idx;
        r_mul_res <= w_mul_res;
        r_mul_cnt <= 2'(MUL_LAT - 1);
        r_neg_q   <= w_a_neg ^ w_b_neg;
        r_neg_r   <= w_a_neg;
        r_is_rem  <= w_is_rem;
        if (!w_is_div && MUL_LAT == 1) r_data <= w_mul_res;
        else if (w_is_div && w_special) r_data <= w_special_res;
      end
      if (r_state == MUL) begin
        r_mul_cnt <= r_mul_cnt - 2'd1;
        if (r_mul_cnt == 2'd1) r_data <= r_mul_res;
      end
      if (r_state == DIV && w_div_done && !w_flush) r_data <= w_div_res;
    end
  end

endmodule
